// File: rtl/clock_divider_multi.sv
// Multi-channel 50%-duty clock divider with per-channel rise ticks and a shared phase-realign strobe.
// Divider and enable changes are only honoured at half-period boundaries, so outputs never glitch.
module clock_divider_multi #(
   parameter int WIDTH    = 16,
   parameter int CHANNELS = 4
) (
   input  logic                      clk_in,
   input  logic                      reset,
   input  logic [CHANNELS*WIDTH-1:0] divider,
   input  logic [CHANNELS-1:0]       enable,
   input  logic                      sync,
   output logic [CHANNELS-1:0]       clk_out,
   output logic [CHANNELS-1:0]       tick,
   output logic [CHANNELS-1:0]       running
);

   localparam logic [0:0]       IDLE = 1'b0;
   localparam logic [0:0]       RUN  = 1'b1;
   localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      logic [0:0]       state_r;
      logic [WIDTH-1:0] n_act_r;
      logic [WIDTH-1:0] count_r;
      logic             clk_r;
      logic             tick_r;
      logic [WIDTH-1:0] div_s;
      logic             go_s;
      logic             term_s;

      assign div_s  = divider[c*WIDTH +: WIDTH];
      assign go_s   = enable[c] && (div_s != ZERO);
      // n_act_r is never zero while in RUN, so the subtraction cannot wrap
      assign term_s = (count_r == (n_act_r - ONE));

      // Per-channel state machine: sync beats a coincident boundary, disable-while-low exits at once
      always_ff @(posedge clk_in) begin
         if (reset) begin
            state_r <= IDLE;
            n_act_r <= ZERO;
            count_r <= ZERO;
            clk_r   <= 1'b0;
            tick_r  <= 1'b0;
         end else begin
            case (state_r)
               IDLE: begin
                  clk_r   <= 1'b0;
                  tick_r  <= 1'b0;
                  count_r <= ZERO;
                  if (go_s) begin
                     state_r <= RUN;
                     n_act_r <= div_s;
                  end else begin
                     state_r <= IDLE;
                  end
               end
               RUN: begin
                  tick_r <= 1'b0;
                  if (sync) begin
                     count_r <= ZERO;
                     clk_r   <= 1'b0;
                     if (go_s) begin
                        n_act_r <= div_s;
                     end else begin
                        state_r <= IDLE;
                     end
                  end else if (!clk_r && !enable[c]) begin
                     state_r <= IDLE;
                     count_r <= ZERO;
                  end else if (term_s) begin
                     count_r <= ZERO;
                     if (!clk_r) begin
                        if (go_s) begin
                           clk_r   <= 1'b1;
                           tick_r  <= 1'b1;
                           n_act_r <= div_s;
                        end else begin
                           state_r <= IDLE;
                        end
                     end else begin
                        clk_r <= 1'b0;
                        if (go_s) begin
                           n_act_r <= div_s;
                        end else begin
                           state_r <= IDLE;
                        end
                     end
                  end else begin
                     count_r <= count_r + ONE;
                  end
               end
               default: begin
                  state_r <= IDLE;
                  n_act_r <= ZERO;
                  count_r <= ZERO;
                  clk_r   <= 1'b0;
                  tick_r  <= 1'b0;
               end
            endcase
         end
      end

      assign clk_out[c] = clk_r;
      assign tick[c]    = tick_r;
      assign running[c] = (state_r == RUN);
   end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Directed bench for clock_divider_multi: a 4-channel WIDTH=16 instance plus a 1-channel WIDTH=4
// instance (modelled as channel 4), with per-cycle expectations queued from closed-form waveforms.
module tb_clock_divider_multi;

   logic        clk_in = 1'b0;
   logic        reset;
   logic [63:0] divider;
   logic [3:0]  enable;
   logic        sync;
   logic [3:0]  clk_out, tick, running;
   logic [3:0]  divider4;
   logic [0:0]  enable4;
   logic [0:0]  clk_out4, tick4, running4;

   typedef struct {
      string      tag;
      logic [4:0] clk;
      logic [4:0] tck;
      logic [4:0] run;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   bit   wave_on[5];
   int   wave_n[5];
   int   wave_k[5];

   clock_divider_multi #(.WIDTH(16), .CHANNELS(4)) dut (
      .clk_in(clk_in), .reset(reset), .divider(divider), .enable(enable), .sync(sync),
      .clk_out(clk_out), .tick(tick), .running(running)
   );

   clock_divider_multi #(.WIDTH(4), .CHANNELS(1)) dut4 (
      .clk_in(clk_in), .reset(reset), .divider(divider4), .enable(enable4), .sync(sync),
      .clk_out(clk_out4), .tick(tick4), .running(running4)
   );

   always #5 clk_in = ~clk_in;

   // Advance one edge, then pop the oldest expectation and compare all outputs against it
   task automatic step();
      exp_t       e;
      logic [4:0] oc, ot, orn;
      @(posedge clk_in);
      #1;
      oc  = {clk_out4, clk_out};
      ot  = {tick4, tick};
      orn = {running4, running};
      n_tests++;
      assert (sb.size() > 0) else begin
         n_fail++;
         $error("FAIL scoreboard_empty got %0d entries required >0", sb.size());
      end
      if (sb.size() > 0) begin
         e = sb.pop_front();
         n_tests++;
         assert (oc === e.clk) else begin
            n_fail++;
            $error("FAIL %s clk_out got %b required %b", e.tag, oc, e.clk);
         end
         n_tests++;
         assert (ot === e.tck) else begin
            n_fail++;
            $error("FAIL %s tick got %b required %b", e.tag, ot, e.tck);
         end
         n_tests++;
         assert (orn === e.run) else begin
            n_fail++;
            $error("FAIL %s running got %b required %b", e.tag, orn, e.run);
         end
      end
   endtask

   // Queue expectations for the next cycles: k edges after a load, clk=(k/N)%2 and tick at k%2N==N
   task automatic run(input string tag, input int cycles);
      for (int i = 0; i < cycles; i++) begin
         exp_t e;
         e.tag = tag;
         e.clk = 5'b00000;
         e.tck = 5'b00000;
         e.run = 5'b00000;
         for (int c = 0; c < 5; c++) begin
            if (wave_on[c]) begin
               wave_k[c]++;
               e.clk[c] = ((wave_k[c] / wave_n[c]) % 2) == 1;
               e.tck[c] = (wave_k[c] % (2 * wave_n[c])) == wave_n[c];
               e.run[c] = 1'b1;
            end
         end
         sb.push_back(e);
      end
      for (int i = 0; i < cycles; i++) step();
   endtask

   task automatic load(input int c, input int n);
      if (c < 4) begin
         divider[c*16 +: 16] = 16'(n);
         enable[c] = 1'b1;
      end else begin
         divider4   = 4'(n);
         enable4[0] = 1'b1;
      end
      wave_on[c] = 1'b1;
      wave_n[c]  = n;
      wave_k[c]  = -1;
   endtask

   initial begin
      for (int c = 0; c < 5; c++) begin
         wave_on[c] = 1'b0;
         wave_n[c]  = 1;
         wave_k[c]  = -1;
      end
      reset    = 1'b1;
      divider  = 64'd0;
      enable   = 4'b0000;
      sync     = 1'b0;
      divider4 = 4'd0;
      enable4  = 1'b0;
      run("reset", 2);
      reset = 1'b0;
      run("idle", 2);

      // basic divide, N=4
      load(0, 4);
      run("basic", 23);
      // divider change two cycles into a high phase: high lasts 4, then period 4
      divider[15:0] = 16'd2;
      run("chg_hold", 1);
      wave_n[0] = 2;
      wave_k[0] = -1;
      run("chg_new", 12);
      // disable exactly at a falling boundary
      enable[0]  = 1'b0;
      wave_on[0] = 1'b0;
      run("dis_bound", 1);

      // disable ch1 two cycles into its high phase
      load(1, 5);
      run("n5", 7);
      enable[1] = 1'b0;
      run("dis_high", 3);
      wave_on[1] = 1'b0;
      run("dis_high_idle", 6);
      // disable ch2 while low
      load(2, 3);
      run("n3", 2);
      enable[2]  = 1'b0;
      wave_on[2] = 1'b0;
      run("dis_low", 2);

      // sync alignment with staggered starts
      load(0, 3);
      run("sync_pre0", 2);
      load(1, 6);
      run("sync_pre1", 4);
      load(2, 3);
      run("sync_pre2", 1);
      sync = 1'b1;
      for (int c = 0; c < 3; c++) wave_k[c] = -1;
      run("sync_edge", 1);
      sync = 1'b0;
      run("sync_after", 15);

      // reset while ch0 is high, then restart from a fresh load
      reset = 1'b1;
      for (int c = 0; c < 3; c++) wave_on[c] = 1'b0;
      run("rst_mid", 1);
      reset = 1'b0;
      for (int c = 0; c < 3; c++) begin
         wave_on[c] = 1'b1;
         wave_k[c]  = -1;
      end
      run("rst_restart", 8);
      reset  = 1'b1;
      enable = 4'b0000;
      for (int c = 0; c < 3; c++) wave_on[c] = 1'b0;
      run("rst_clear", 1);
      reset = 1'b0;
      run("rst_idle", 2);

      // N=1 toggling, divider=0 with enable stays idle
      load(3, 1);
      divider[47:32] = 16'd0;
      enable[2]      = 1'b1;
      run("n1_div0", 6);
      // WIDTH=4 with maximum N=15: period 30, no counter overflow
      load(4, 15);
      run("w4_n15", 62);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
